conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
Streaming sliding-window generator that produces the flat KERNEL_SIZE x KERNEL_SIZE pixel window consumed by the convolver datapath's pixel_data input. Raster-order pixels are accepted one per cycle through a valid/ready handshake. KERNEL_SIZE-1 line buffers plus a KxK register window build each window, and one window is emitted per valid output position. It sits between the image source and the multiplier/adder-tree datapath.

Parameters:
DATA_WIDTH, 16, bits per pixel (signed).
KERNEL_SIZE, 5, window edge length K.
IMAGE_WIDTH, 28, pixels per row W (W >= K).
IMAGE_HEIGHT, 28, rows per frame H (H >= K).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset.
pixel_in  in  DATA_WIDTH  signed input pixel, raster order.
pixel_valid  in  1  pixel_in is valid this cycle.
pixel_ready  out  1  block accepts pixel_in this cycle.
window_out  out  K*K*DATA_WIDTH  packed window for datapath pixel_data.
window_valid  out  1  window_out holds a valid window.
window_ready  in  1  downstream consumes window_out this cycle.
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (reset==0 at a clk edge): col=0, row=0, window_valid=0, window_out=0, frame_done=0. Line buffer and window registers need not clear. Reset takes priority over all other activity, including in mid-frame.
- pixel_ready = !window_valid || window_ready, combinational from output state only.
- Accept: pixel_valid && pixel_ready. Nothing changes on cycles without an accept, except the output handshake.
- On each accept: shift the KxK window left by one column. The new right column holds the K-1 line buffer outputs for the current col plus pixel_in, with pixel_in in the bottom row. Write the line buffers so the pixel from k rows above is available at the same col. The window and line buffers update on every accept, including col < K-1 and row < K-1.
- Counters: col increments on each accept. At col==W-1, col wraps to 0 and row increments. At row==H-1 and col==W-1, both wrap to 0 and frame_done pulses high for exactly the next cycle.
- Window emission: an accept at (row>=K-1, col>=K-1) loads window_out and sets window_valid=1 on the next edge (latency 1 cycle from accept). Accepts at other positions load nothing.
- Window contents for an accept at (R,C): element index k = r*K + c (r=0 top/oldest row, c=0 leftmost column) holds image pixel (R-K+1+r, C-K+1+c), at bits [k*DATA_WIDTH +: DATA_WIDTH].
- Output handshake: window_valid && window_ready consumes the window. window_valid clears unless a new window is loaded on the same edge. While window_valid && !window_ready, window_out is held stable and pixel_ready=0, so no pixel is lost.
- Simultaneous consume and new emitting accept: window_out is replaced and window_valid stays 1.
- Windows per frame = (W-K+1)*(H-K+1); 576 at defaults. None span a row wrap or a frame boundary. Stale line-buffer data from the previous frame is never emitted, because emission is gated by row>=K-1.
- frame_done does not depend on window_ready. The final window of a frame and frame_done can both be outstanding at the same time.
- No arithmetic on pixel values; the block only moves data, and signedness is preserved bit-exact.

Test Plan:
- Defaults, pixel(r,c)=r*32+c, pixel_valid always 1, window_ready always 1. The first window_valid comes 1 cycle after accepting (4,4), with element0=0, element12=66, element24=132.
- Same full frame: exactly 576 window_valid cycles. The last window has element24=27*32+27=891 and element0=23*32+23=759. frame_done pulses once, in the cycle after (27,27) is accepted.
- Backpressure: drop window_ready for 3 cycles after the first window. window_out stays at its value (element0=0), pixel_ready=0 for those cycles, and the next window after release has element0=1 with no skipped pixel.
- Random pixel_valid bubbles (50%) across the frame: the window sequence is identical to the no-bubble run, compared against a software reference model.
- Two back-to-back frames with the second frame offset by +1000: no window before frame-2 pixel (4,4) is accepted. The first frame-2 window has element0=1000.
- Hold reset low for 1 cycle at frame pixel (10,10): window_valid=0 and frame_done=0 next cycle, counters restart, and the next full frame yields 576 correct windows.

Source files
------------

// File: rtl/conv_window_gen_if.sv
// rtl/conv_window_gen_if.sv - pixel-in / window-out stream bundle for conv_window_gen
interface conv_window_gen_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5
);
  logic signed [DATA_WIDTH-1:0]                      pixel_in;
  logic                                              pixel_valid;
  logic                                              pixel_ready;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     window_out;
  logic                                              window_valid;
  logic                                              window_ready;
  logic                                              frame_done;

  modport master (
    output pixel_in, pixel_valid, window_ready,
    input  pixel_ready, window_out, window_valid, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid, window_ready,
    output pixel_ready, window_out, window_valid, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster-order KxK sliding-window generator
// K-1 line buffers feed the right column of a KxK shift window; one window per valid position.
module conv_window_gen #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_window_gen_if.slave      bus
);
  localparam int K  = KERNEL_SIZE;
  localparam int W  = IMAGE_WIDTH;
  localparam int H  = IMAGE_HEIGHT;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // line_buf[K-2] holds the row directly above, line_buf[0] the oldest row
  logic signed [DATA_WIDTH-1:0] line_buf [K-1][W];
  logic signed [DATA_WIDTH-1:0] win      [K][K];
  logic signed [DATA_WIDTH-1:0] win_next [K][K];
  logic [K*K*DATA_WIDTH-1:0]    win_flat;

  logic accept;
  logic last_col;
  logic last_row;
  logic emit;

  assign bus.pixel_ready = !bus.window_valid || bus.window_ready;
  assign accept          = bus.pixel_valid && bus.pixel_ready;
  assign last_col        = (col == CW'(W - 1));
  assign last_row        = (row == RW'(H - 1));
  assign emit            = accept && (row >= RW'(K - 1)) && (col >= CW'(K - 1));

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_next[r][c] = win[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_next[r][K-1] = line_buf[r][col];
    end
    win_next[K-1][K-1] = bus.pixel_in;
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_next[r][c];
      end
    end
  end

  // Pixel storage carries no reset: stale contents are never emitted
  always_ff @(posedge clk) begin
    if (accept) begin
      win <= win_next;
      for (int j = 0; j < K - 2; j++) begin
        line_buf[j][col] <= line_buf[j+1][col];
      end
      line_buf[K-2][col] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col              <= '0;
      row              <= '0;
      bus.window_valid <= 1'b0;
      bus.window_out   <= '0;
      bus.frame_done   <= 1'b0;
    end else begin
      bus.frame_done <= accept && last_col && last_row;

      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (emit) begin
        bus.window_out   <= win_flat;
        bus.window_valid <= 1'b1;
      end else if (bus.window_ready) begin
        bus.window_valid <= 1'b0;
      end
    end
  end
endmodule
